// File: rtl/match_detector_if.sv
// Bus bundle for match_detector: target programming, arm/clear control and hit reporting.
// The master side drives compare inputs; the slave side (the detector) returns status.
interface match_detector_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    value;
    logic                tgt_we;
    logic [SEL_W-1:0]    tgt_sel;
    logic [WIDTH-1:0]    tgt_data;
    logic                tgt_mode;
    logic [CHANNELS-1:0] ch_en;
    logic                arm;
    logic                clear;
    logic                armed;
    logic                hit;
    logic                hit_pulse;
    logic [SEL_W-1:0]    hit_ch;
    logic [CNT_W-1:0]    hit_cnt;

    modport master (
        output value, tgt_we, tgt_sel, tgt_data, tgt_mode, ch_en, arm, clear,
        input  armed, hit, hit_pulse, hit_ch, hit_cnt
    );

    modport slave (
        input  value, tgt_we, tgt_sel, tgt_data, tgt_mode, ch_en, arm, clear,
        output armed, hit, hit_pulse, hit_ch, hit_cnt
    );
endinterface

// File: rtl/match_detector.sv
// Multi-channel registered value/target comparator with an arm/hit/clear FSM.
// Captures the lowest-index channel that hits, pulses once per hit, counts hits (saturating).
module match_detector #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic            clk,
    input logic            rst,
    match_detector_if.slave bus
);
    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StHit} state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    target_q [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic                hit_pulse_q;
    logic [SEL_W-1:0]    hit_ch_q;
    logic [CNT_W-1:0]    hit_cnt_q;

    logic [CHANNELS-1:0] match;
    logic                any_match;
    logic [SEL_W-1:0]    first_ch;

    // ch_en is deliberately used unregistered against the registered value.
    always_comb begin
        match    = '0;
        first_ch = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            match[i] = bus.ch_en[i] & (mode_q[i] ? (value_q >= target_q[i])
                                                 : (value_q == target_q[i]));
        end
        any_match = |match;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (match[i]) first_ch = SEL_W'(i);
        end
    end

    // Out-of-range tgt_sel never equals any channel index, so it writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            mode_q  <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) target_q[i] <= '0;
        end else begin
            value_q <= bus.value;
            if (bus.tgt_we) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (bus.tgt_sel == SEL_W'(i)) begin
                        target_q[i] <= bus.tgt_data;
                        mode_q[i]   <= bus.tgt_mode;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hit_pulse_q <= 1'b0;
            hit_ch_q    <= '0;
            hit_cnt_q   <= '0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (bus.clear) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.arm) state_q <= StArmed;
                    end
                    StArmed: begin
                        if (any_match) begin
                            state_q     <= StHit;
                            hit_pulse_q <= 1'b1;
                            hit_ch_q    <= first_ch;
                            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                        end
                    end
                    StHit:   state_q <= StHit;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.armed     = (state_q == StArmed);
    assign bus.hit       = (state_q == StHit);
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.hit_ch    = hit_ch_q;
    assign bus.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_match_detector.sv
// Bench for match_detector: directed scenarios plus random traffic against a behavioural model.
// A second instance (5 channels, 2-bit counter) covers saturation and out-of-range target writes.
module tb_match_detector;
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    always #5 clk = ~clk;

    match_detector_if #(.WIDTH(16), .CHANNELS(4), .CNT_W(8)) bus ();
    match_detector_if #(.WIDTH(16), .CHANNELS(5), .CNT_W(2)) bus_b ();

    match_detector #(.WIDTH(16), .CHANNELS(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    match_detector #(.WIDTH(16), .CHANNELS(5), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Reference model: state 0=idle, 1=armed, 2=hit
    logic [15:0] m_tgt [4];
    logic        m_mode [4];
    logic [15:0] m_vq;
    int          m_state;
    logic        m_pulse;
    int          m_ch;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock on the main DUT, update the model from the spec rules, compare.
    task automatic step();
        int first;
        first = -1;
        for (int i = 3; i >= 0; i--) begin
            if (bus.ch_en[i] && (m_mode[i] ? (m_vq >= m_tgt[i]) : (m_vq == m_tgt[i])))
                first = i;
        end
        m_pulse = 1'b0;
        if (rst) begin
            m_state = 0;
            m_ch    = 0;
            m_cnt   = 0;
            m_vq    = '0;
            for (int i = 0; i < 4; i++) begin
                m_tgt[i]  = '0;
                m_mode[i] = 1'b0;
            end
        end else begin
            if (bus.clear) m_state = 0;
            else if (m_state == 0 && bus.arm) m_state = 1;
            else if (m_state == 1 && first >= 0) begin
                m_state = 2;
                m_pulse = 1'b1;
                m_ch    = first;
                if (m_cnt < 255) m_cnt++;
            end
            if (bus.tgt_we) begin
                m_tgt[bus.tgt_sel]  = bus.tgt_data;
                m_mode[bus.tgt_sel] = bus.tgt_mode;
            end
            m_vq = bus.value;
        end
        tick();
        check("model_armed", bus.armed, (m_state == 1));
        check("model_hit", bus.hit, (m_state == 2));
        check("model_pulse", bus.hit_pulse, m_pulse);
        check("model_hit_ch", bus.hit_ch, m_ch);
        check("model_hit_cnt", bus.hit_cnt, m_cnt);
        if (bus.hit_pulse) pulses++;
    endtask

    task automatic write_tgt(input logic [1:0] sel, input logic [15:0] data, input logic mode);
        bus.tgt_we   = 1'b1;
        bus.tgt_sel  = sel;
        bus.tgt_data = data;
        bus.tgt_mode = mode;
        step();
        bus.tgt_we   = 1'b0;
    endtask

    initial begin
        logic [1:0] sat_exp [4];
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;

        rst = 1'b1;
        rst_b = 1'b1;
        bus.value = '0; bus.tgt_we = 1'b0; bus.tgt_sel = '0; bus.tgt_data = '0;
        bus.tgt_mode = 1'b0; bus.ch_en = '0; bus.arm = 1'b0; bus.clear = 1'b0;
        bus_b.value = '0; bus_b.tgt_we = 1'b0; bus_b.tgt_sel = '0; bus_b.tgt_data = '0;
        bus_b.tgt_mode = 1'b0; bus_b.ch_en = '0; bus_b.arm = 1'b0; bus_b.clear = 1'b0;

        // Reset held with arm asserted
        bus.arm = 1'b1;
        step();
        step();
        check("rst_armed", bus.armed, 1'b0);
        check("rst_hit", bus.hit, 1'b0);
        check("rst_pulse", bus.hit_pulse, 1'b0);
        check("rst_cnt", bus.hit_cnt, 0);
        rst = 1'b0;
        bus.arm = 1'b0;
        step();

        // EQ hit on channel 2 with a ramp
        write_tgt(2'd2, 16'h0123, 1'b0);
        bus.ch_en = 4'b0100;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        pulses = 0;
        for (int v = 'h120; v <= 'h126; v++) begin
            bus.value = 16'(v);
            step();
            if (v == 'h124) check("eq_pulse_time", bus.hit_pulse, 1'b1);
        end
        step();
        step();
        check("eq_pulses", pulses, 1);
        check("eq_hit_ch", bus.hit_ch, 2);
        check("eq_hit_cnt", bus.hit_cnt, 1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;

        // Lowest index wins; held match neither re-pulses nor re-counts
        write_tgt(2'd1, 16'd50, 1'b1);
        write_tgt(2'd3, 16'd50, 1'b0);
        bus.ch_en = 4'hF;
        bus.value = 16'd10;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        step();
        pulses = 0;
        bus.value = 16'd50;
        for (int k = 0; k < 10; k++) step();
        check("prio_pulses", pulses, 1);
        check("prio_hit_ch", bus.hit_ch, 1);
        check("prio_hit_cnt", bus.hit_cnt, 2);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;

        // Clear coinciding with a match wins
        bus.ch_en = 4'b0100;
        bus.value = 16'h0100;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        bus.value = 16'h0123;
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_armed", bus.armed, 1'b0);
        check("clr_hit", bus.hit, 1'b0);
        check("clr_pulse", bus.hit_pulse, 1'b0);
        check("clr_cnt", bus.hit_cnt, 2);
        step();
        check("clr_idle_no_hit", bus.hit, 1'b0);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        step();
        check("rearm_hit", bus.hit, 1'b1);
        check("rearm_cnt", bus.hit_cnt, 3);

        // Arm during HIT ignored; idle and disabled matches ignored
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        check("arm_in_hit", bus.hit, 1'b1);
        check("arm_in_hit_armed", bus.armed, 1'b0);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("idle_match", bus.hit, 1'b0);
        bus.ch_en = 4'b0000;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("dis_armed", bus.armed, 1'b1);
        check("dis_hit", bus.hit, 1'b0);

        // Random traffic with a small value range so matches are frequent
        for (int k = 0; k < 400; k++) begin
            bus.tgt_we   = ($urandom_range(0, 3) == 0);
            bus.tgt_sel  = 2'($urandom_range(0, 3));
            bus.tgt_data = 16'($urandom_range(0, 15));
            bus.tgt_mode = 1'($urandom_range(0, 1));
            bus.value    = 16'($urandom_range(0, 15));
            bus.ch_en    = 4'($urandom_range(0, 15));
            bus.arm      = ($urandom_range(0, 3) == 0);
            bus.clear    = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        // Saturating 2-bit counter on the second instance
        tick();
        rst_b = 1'b0;
        bus_b.tgt_we = 1'b1;
        bus_b.tgt_sel = 3'd0;
        bus_b.tgt_data = 16'd100;
        bus_b.tgt_mode = 1'b0;
        tick();
        bus_b.tgt_we = 1'b0;
        bus_b.ch_en = 5'b00001;
        bus_b.value = 16'd100;
        for (int k = 0; k < 4; k++) begin
            bus_b.arm = 1'b1;
            tick();
            bus_b.arm = 1'b0;
            tick();
            check("sat_hit", bus_b.hit, 1'b1);
            check("sat_cnt", bus_b.hit_cnt, sat_exp[k]);
            bus_b.clear = 1'b1;
            tick();
            bus_b.clear = 1'b0;
        end

        // Out-of-range target select must not alias onto any channel
        bus_b.value = 16'd5;
        bus_b.tgt_we = 1'b1;
        bus_b.tgt_sel = 3'd7;
        bus_b.tgt_data = 16'd5;
        bus_b.tgt_mode = 1'b1;
        tick();
        bus_b.tgt_we = 1'b0;
        bus_b.ch_en = 5'h1F;
        bus_b.arm = 1'b1;
        tick();
        bus_b.arm = 1'b0;
        tick();
        tick();
        check("oor_armed", bus_b.armed, 1'b1);
        check("oor_hit", bus_b.hit, 1'b0);
        bus_b.value = 16'd100;
        tick();
        tick();
        check("oor_ch0_hit", bus_b.hit, 1'b1);
        check("oor_ch0_idx", bus_b.hit_ch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
